// File: rtl/dly_load_seq.sv
// Sequencer that loads 8-bit delays into NUM_LANES input-delay lanes and issues one global set strobe.
// Shadow registers and the registered readback port exist only when DLY_LOAD_SEQ_READBACK_EN is defined.
module dly_load_seq #(
  parameter int          NUM_LANES  = 8,
  parameter int          ADDR_WIDTH = 5,
  parameter int          SET_GAP    = 2,
  parameter logic [7:0]  INIT_DELAY = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_commit,
  input  logic                  cmd_bcast,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_data,
  output logic [7:0]            dly_data,
  output logic [NUM_LANES-1:0]  dly_ld,
  output logic                  dly_set,
  output logic                  busy,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  typedef enum logic [1:0] {IDLE, GAP, SET} state_t;

  localparam logic [3:0] GAP_LOAD = (SET_GAP == 0) ? 4'd0 : 4'(SET_GAP - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            dly_data_q, dly_data_d;
  logic [NUM_LANES-1:0]  dly_ld_q, dly_ld_d;
  logic                  dly_set_q, dly_set_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  cmd_accept;
  logic [NUM_LANES-1:0]  lane_hit;
  logic [NUM_LANES-1:0]  wr_mask;
  logic                  in_range;
  logic                  wr_en;

  // Ready depends only on state and reset, never on the command inputs.
  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    lane_hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_hit[i] = (cmd_addr == ADDR_WIDTH'(i));
    end
  end

  assign in_range = |lane_hit;
  assign wr_mask  = cmd_bcast ? {NUM_LANES{1'b1}} : lane_hit;
  assign wr_en    = cmd_accept && !cmd_commit && (cmd_bcast || in_range);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dly_data_d = dly_data_q;
    dly_ld_d   = '0;
    dly_set_d  = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (cmd_accept) begin
          if (cmd_commit) begin
            busy_d = 1'b1;
            if (SET_GAP == 0) begin
              state_d   = SET;
              dly_set_d = 1'b1;
            end else begin
              state_d = GAP;
              cnt_d   = GAP_LOAD;
            end
          end else if (wr_en) begin
            dly_data_d = cmd_data;
            dly_ld_d   = wr_mask;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          state_d   = SET;
          dly_set_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SET: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      dly_data_q <= 8'h00;
      dly_ld_q   <= '0;
      dly_set_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_data_q <= dly_data_d;
      dly_ld_q   <= dly_ld_d;
      dly_set_q  <= dly_set_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign dly_data = dly_data_q;
  assign dly_ld   = dly_ld_q;
  assign dly_set  = dly_set_q;
  assign busy     = busy_q;
  assign err      = err_q;

`ifdef DLY_LOAD_SEQ_READBACK_EN
  logic [7:0] shadow_q [NUM_LANES];
  logic [7:0] shadow_d [NUM_LANES];
  logic [7:0] rd_data_q, rd_data_d;

  // Readback returns the pre-update shadow, so a write is visible two cycles after acceptance.
  always_comb begin
    shadow_d  = shadow_q;
    rd_data_d = 8'h00;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_en && wr_mask[i]) begin
        shadow_d[i] = cmd_data;
      end
      if (rd_addr == ADDR_WIDTH'(i)) begin
        rd_data_d = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        shadow_q[i] <= INIT_DELAY;
      end
      rd_data_q <= 8'h00;
    end else begin
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = 8'h00;
`endif

endmodule

// File: tb/tb_dly_load_seq.sv
// Bench for dly_load_seq: cycle-scheduled reference model plus directed vectors with literal expectations.
module tb_dly_load_seq;

  localparam int NL = 8;
  localparam int AW = 5;
  localparam int G  = 2;
  localparam logic [7:0] INIT = 8'h00;
`ifdef DLY_LOAD_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_commit = 1'b0;
  logic          cmd_bcast = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_data = 8'h00;
  logic [7:0]    dly_data;
  logic [NL-1:0] dly_ld;
  logic          dly_set;
  logic          busy;
  logic          err;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;

  dly_load_seq #(
    .NUM_LANES(NL), .ADDR_WIDTH(AW), .SET_GAP(G), .INIT_DELAY(INIT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_commit(cmd_commit), .cmd_bcast(cmd_bcast), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .dly_data(dly_data), .dly_ld(dly_ld), .dly_set(dly_set),
    .busy(busy), .err(err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: cycle k is the interval after clock edge k.
  int          cyc = 0;
  int          n_in;
  int          ready_from = 0;
  int          set_cyc = -1;
  int          busy_lo = 0;
  logic [7:0]  m_sh [NL];
  logic [NL-1:0] e_ld = '0;
  logic [7:0]  e_data = 8'h00;
  logic [7:0]  e_rd = 8'h00;
  logic        e_set = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_err = 1'b0;

  always @(posedge clk) begin
    n_in = cyc;
    cyc  = cyc + 1;
    if (rst) begin
      ready_from = 0;
      set_cyc    = -1;
      busy_lo    = 0;
      for (int i = 0; i < NL; i++) m_sh[i] = INIT;
      e_ld = '0; e_data = 8'h00; e_rd = 8'h00; e_set = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    end else begin
      e_ld = '0;
      e_rd = 8'h00;
      for (int i = 0; i < NL; i++)
        if (int'(rd_addr) == i && RB) e_rd = m_sh[i];
      if (cmd_valid && n_in >= ready_from) begin
        if (cmd_commit) begin
          busy_lo    = n_in + 1;
          set_cyc    = n_in + 1 + G;
          ready_from = set_cyc + 1;
        end else if (cmd_bcast) begin
          e_ld   = '1;
          e_data = cmd_data;
          for (int i = 0; i < NL; i++) m_sh[i] = cmd_data;
        end else if (int'(cmd_addr) < NL) begin
          e_data = cmd_data;
          for (int i = 0; i < NL; i++)
            if (int'(cmd_addr) == i) begin
              e_ld[i] = 1'b1;
              m_sh[i] = cmd_data;
            end
        end else begin
          e_err = 1'b1;
        end
      end
      e_set  = (cyc == set_cyc);
      e_busy = (cyc >= busy_lo) && (cyc <= set_cyc);
    end
  end

  always @(posedge clk) begin
    #2;
    chk("ld_model",    32'(dly_ld),    32'(e_ld));
    chk("data_model",  32'(dly_data),  32'(e_data));
    chk("set_model",   32'(dly_set),   32'(e_set));
    chk("busy_model",  32'(busy),      32'(e_busy));
    chk("err_model",   32'(err),       32'(e_err));
    chk("rd_model",    32'(rd_data),   32'(e_rd));
    chk("ready_model", 32'(cmd_ready), 32'(!rst && (cyc >= ready_from)));
  end

  int set_seen = -100;
  int n_set = 0;
  always @(posedge clk) begin
    #2;
    if (dly_set) begin
      set_seen = cyc;
      n_set++;
    end
  end

  task automatic send(input bit commit, input bit bcast, input logic [AW-1:0] addr,
                      input logic [7:0] data, output int acc);
    int k;
    k = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_commit = commit; cmd_bcast = bcast; cmd_addr = addr; cmd_data = data;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=0 required ready=1 within 50 cycles");
      cmd_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0; cmd_commit = 1'b0; cmd_bcast = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [7:0] exp_rb, input string nm);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #2;
    chk(nm, 32'(rd_data), RB ? 32'(exp_rb) : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int snap;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_ld",    32'(dly_ld),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(1'b0, 1'b0, 5'd3, 8'h5A, acc);
    #2;
    chk("wr3_ld",   32'(dly_ld),   32'h08);
    chk("wr3_data", 32'(dly_data), 32'h5A);
    idle();
    rd(5'd3, 8'h5A, "rb_lane3");
    rd(5'd0, 8'h00, "rb_lane0_init");

    send(1'b0, 1'b1, 5'd6, 8'hC3, acc);
    #2;
    chk("bc_ld",   32'(dly_ld),   32'hFF);
    chk("bc_data", 32'(dly_data), 32'hC3);
    idle();
    #2;
    chk("data_hold", 32'(dly_data), 32'hC3);
    for (int i = 0; i < NL; i++) rd(AW'(i), 8'hC3, "rb_bcast");

    send(1'b0, 1'b0, 5'd0, 8'h11, acc);
    #2; chk("b2b_ld0", 32'(dly_ld), 32'h01);
    send(1'b0, 1'b0, 5'd1, 8'h22, acc);
    #2; chk("b2b_ld1", 32'(dly_ld), 32'h02);
    send(1'b0, 1'b0, 5'd2, 8'h33, acc);
    #2; chk("b2b_ld2", 32'(dly_ld), 32'h04);
    send(1'b1, 1'b0, 5'd0, 8'h00, acc);
    #2;
    chk("commit_busy",  32'(busy),      32'h1);
    chk("commit_ready", 32'(cmd_ready), 32'h0);
    idle();
    repeat (G + 3) @(posedge clk);
    #3;
    chk("set_latency", 32'(set_seen - acc), 32'(G + 1));
    chk("ready_after", 32'(cmd_ready), 32'h1);
    rd(5'd1, 8'h22, "rb_lane1");

    send(1'b0, 1'b0, 5'd9, 8'hEE, acc);
    #2;
    chk("oor_ld",  32'(dly_ld), 32'h0);
    chk("oor_err", 32'(err),    32'h1);
    idle();
    rd(5'd9, 8'h00, "rb_oor");
    send(1'b0, 1'b0, 5'd5, 8'h77, acc);
    send(1'b1, 1'b0, 5'd0, 8'h00, acc);
    idle();
    repeat (G + 3) @(posedge clk);
    #3;
    chk("err_sticky", 32'(err), 32'h1);
    rd(5'd5, 8'h77, "rb_lane5");
    rd(5'd2, 8'h33, "rb_lane2");

    send(1'b1, 1'b0, 5'd0, 8'h00, acc);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_commit = 1'b0;
    #1;
    chk("arst_busy",  32'(busy),      32'h0);
    chk("arst_err",   32'(err),       32'h0);
    chk("arst_data",  32'(dly_data),  32'h0);
    chk("arst_set",   32'(dly_set),   32'h0);
    chk("arst_ready", 32'(cmd_ready), 32'h0);
    chk("arst_rd",    32'(rd_data),   32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap = n_set;
    repeat (10) @(posedge clk);
    #3;
    chk("no_set_after_abort", 32'(n_set), 32'(snap));
    rd(5'd5, INIT, "rb_after_rst5");
    rd(5'd3, INIT, "rb_after_rst3");
    repeat (2) @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
